aer_req_rx: RTL and testbench

Four-phase AER request receiver between the chip's asynchronous spike-request line and the landscape-sampling core. Synchronises the chip's `chip_req`, completes the req/ack handshake back to the chip, and emits exactly one single-cycle `request_z` pulse per accepted event on `clk_main`. That pulse is the `request_z` input of the sampling core, which then stretches it into its timestamp. The block also keeps a saturating event count and a sticky timeout flag for handshakes the chip never releases.

---
 rtl/aer_req_rx_pkg.sv | 21 ++
 rtl/aer_req_rx_sync_ff.sv | 25 ++
 rtl/aer_req_rx.sv | 136 +++++++++++++
 tb/tb_aer_req_rx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aer_req_rx_pkg.sv
// Shared definitions for the AER request receiver: handshake FSM states and
// the default timing constants the sampling top level also relies on.
package aer_req_rx_pkg;

    // Handshake FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK   = 2'd1,
        ST_ABORT = 2'd2
    } aer_state_e;

    // Default synchroniser depth for chip_req
    localparam int DEF_SYNC_STAGES = 2;
    // Default minimum number of cycles chip_ack stays high
    localparam int DEF_ACK_HOLD    = 4;
    // Default number of ACK cycles before a stuck request is aborted
    localparam int DEF_TIMEOUT     = 1024;
    // Default event counter width
    localparam int DEF_BIT_CNT     = 16;

endpackage : aer_req_rx_pkg

// File: rtl/aer_req_rx_sync_ff.sv
// sync_ff: a stages-deep flip-flop synchroniser for an asynchronous
// single-bit input. Reusable for any other chip-side input.
module aer_req_rx_sync_ff #(
    parameter int stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [stages-1:0] sync_q;

    // Shift the raw input through the chain; only the last flop is used.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[stages-1];

endmodule : aer_req_rx_sync_ff

// File: rtl/aer_req_rx.sv
// aer_req_rx: four-phase AER request receiver. Synchronises chip_req,
// answers it with chip_ack, emits one request_z pulse per accepted event,
// keeps a saturating event count and a sticky handshake-timeout flag.
//
// Handshake semantics: an event is accepted only in IDLE when en=1 and the
// synchronised request is high; acceptance raises chip_ack and request_z on
// the same clock edge. chip_ack stays high for at least ack_hold cycles and
// drops once the synchronised request is low; a request still high after
// timeout ACK cycles is aborted (chip_ack drops, err_timeout set) and the
// block waits for the request to fall before accepting anything new.
module aer_req_rx
    import aer_req_rx_pkg::*;
#(
    parameter int sync_stages = DEF_SYNC_STAGES,
    parameter int ack_hold    = DEF_ACK_HOLD,
    parameter int timeout     = DEF_TIMEOUT,
    parameter int bit_cnt     = DEF_BIT_CNT
) (
    input  logic               clk_main,
    input  logic               rst,
    input  logic               chip_req,
    input  logic               en,
    input  logic               clr_err,
    output logic               chip_ack,
    output logic               request_z,
    output logic [bit_cnt-1:0] evt_cnt,
    output logic               err_timeout,
    output aer_state_e         dbg_state_o
);

    // Hold/timeout counter must be able to hold the value timeout.
    localparam int CW = $clog2(timeout + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(ack_hold - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(timeout - 1);
    localparam logic [CW-1:0] TO_MAX    = CW'(timeout);

    logic               req_s;
    aer_state_e         state_q, state_d;
    logic [CW-1:0]      hold_cnt_q, hold_cnt_d;
    logic               chip_ack_q, chip_ack_d;
    logic               request_z_q, request_z_d;
    logic [bit_cnt-1:0] evt_cnt_q, evt_cnt_d;
    logic               err_q, err_d;
    logic               accept;
    logic               timeout_hit;

    aer_req_rx_sync_ff #(
        .stages (sync_stages)
    ) u_sync_req (
        .clk_i  (clk_main),
        .rst_ni (rst),
        .d_i    (chip_req),
        .q_o    (req_s)
    );

    // Next-state logic: handshake FSM, hold/timeout counter, event counter
    // and the sticky error flag.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        evt_cnt_d   = evt_cnt_q;
        err_d       = err_q;
        accept      = 1'b0;
        timeout_hit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && req_s) begin
                    state_d    = ST_ACK;
                    accept     = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_ACK: begin
                if (hold_cnt_q != TO_MAX) begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
                if ((hold_cnt_q >= HOLD_LAST) && !req_s) begin
                    state_d = ST_IDLE;
                end else if ((hold_cnt_q == TO_LAST) && req_s) begin
                    state_d     = ST_ABORT;
                    timeout_hit = 1'b1;
                end
            end
            ST_ABORT: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Saturation guard on the counter enable: all-ones holds.
        if (accept && (evt_cnt_q != {bit_cnt{1'b1}})) begin
            evt_cnt_d = evt_cnt_q + bit_cnt'(1);
        end

        // A timeout in the same cycle as clr_err leaves the flag set.
        if (timeout_hit) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end

        request_z_d = accept;
        chip_ack_d  = (state_d == ST_ACK);
    end

    // State and output registers; reset drops chip_ack immediately.
    always_ff @(posedge clk_main or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            chip_ack_q  <= 1'b0;
            request_z_q <= 1'b0;
            evt_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            chip_ack_q  <= chip_ack_d;
            request_z_q <= request_z_d;
            evt_cnt_q   <= evt_cnt_d;
            err_q       <= err_d;
        end
    end

    assign chip_ack    = chip_ack_q;
    assign request_z   = request_z_q;
    assign evt_cnt     = evt_cnt_q;
    assign err_timeout = err_q;
    assign dbg_state_o = state_q;

endmodule : aer_req_rx

// File: tb/tb_aer_req_rx.sv
// Testbench for aer_req_rx: directed and randomized handshakes checked
// against a handshake-level model (latency, ack width, timeout, counts).
module tb_aer_req_rx;
    import aer_req_rx_pkg::*;

    localparam int SYNC = 2;
    localparam int HOLD = 4;
    localparam int TO   = 1024;

    logic        clk;
    logic        rst;
    logic        chip_req;
    logic        en;
    logic        clr_err;
    logic        chip_ack;
    logic        request_z;
    logic [15:0] evt_cnt;
    logic        err_timeout;
    aer_state_e  dbg_state;

    logic        req2;
    logic        ack2;
    logic        pz2;
    logic [1:0]  cnt2;
    logic        err2;
    aer_state_e  state2;

    int n_checks = 0;
    int n_pass   = 0;
    int evt_exp  = 0;
    bit err_m    = 1'b0;

    aer_req_rx dut (
        .clk_main    (clk),
        .rst         (rst),
        .chip_req    (chip_req),
        .en          (en),
        .clr_err     (clr_err),
        .chip_ack    (chip_ack),
        .request_z   (request_z),
        .evt_cnt     (evt_cnt),
        .err_timeout (err_timeout),
        .dbg_state_o (dbg_state)
    );

    aer_req_rx #(
        .bit_cnt (2)
    ) dut_sat (
        .clk_main    (clk),
        .rst         (rst),
        .chip_req    (req2),
        .en          (1'b1),
        .clr_err     (1'b0),
        .chip_ack    (ack2),
        .request_z   (pz2),
        .evt_cnt     (cnt2),
        .err_timeout (err2),
        .dbg_state_o (state2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One handshake of h request-high cycles followed by g low cycles,
    // checked cycle by cycle against the handshake-level model. clr_at
    // pulses clr_err after that edge (negative = never).
    task automatic run_hs(input int h, input int g, input int clr_at);
        int   a;
        logic exp_pz, exp_ack;
        bit   set_c, clr_c;
        // ack width: the longer of request length and hold, capped by abort
        a = (h > TO) ? TO : ((h > HOLD) ? h : HOLD);
        @(posedge clk); #1 chip_req = 1'b1;
        for (int c = 1; c <= h + g; c++) begin
            @(posedge clk); #1;
            if (c == h) chip_req = 1'b0;
            clr_err = (c == clr_at);
            @(negedge clk);
            set_c = (h > TO) && (c == SYNC + 1 + TO);
            clr_c = (c == clr_at + 1);
            if (set_c) err_m = 1'b1;
            else if (clr_c) err_m = 1'b0;
            exp_pz  = (c == SYNC + 1);
            exp_ack = (c >= SYNC + 1) && (c < SYNC + 1 + a);
            n_checks++;
            if (request_z !== exp_pz)
                $display("FAIL hs_pulse h=%0d c=%0d got=%b exp=%b", h, c, request_z, exp_pz);
            else n_pass++;
            n_checks++;
            if (chip_ack !== exp_ack)
                $display("FAIL hs_ack h=%0d c=%0d got=%b exp=%b", h, c, chip_ack, exp_ack);
            else n_pass++;
            n_checks++;
            if (err_timeout !== err_m)
                $display("FAIL hs_err h=%0d c=%0d got=%b exp=%b", h, c, err_timeout, err_m);
            else n_pass++;
        end
        clr_err = 1'b0;
        evt_exp++;
        n_checks++;
        if (evt_cnt !== 16'(evt_exp))
            $display("FAIL hs_evt_cnt h=%0d got=%0d exp=%0d", h, evt_cnt, evt_exp);
        else n_pass++;
        n_checks++;
        if (dbg_state !== ST_IDLE)
            $display("FAIL hs_end_state h=%0d got=%0d exp=%0d", h, dbg_state, ST_IDLE);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b0; chip_req = 1'b0; en = 1'b1; clr_err = 1'b0; req2 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({chip_ack, request_z, err_timeout} !== 3'b000)
            $display("FAIL reset_flags got=%b exp=000", {chip_ack, request_z, err_timeout});
        else n_pass++;
        n_checks++;
        if (evt_cnt !== 16'd0) $display("FAIL reset_evt_cnt got=%0d exp=0", evt_cnt);
        else n_pass++;
        n_checks++;
        if (dbg_state !== ST_IDLE) $display("FAIL reset_state got=%0d exp=0", dbg_state);
        else n_pass++;
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        run_hs(10, 8, -10);
    endtask

    task automatic test_short();
        run_hs(2, 8, -10);
    endtask

    task automatic test_random();
        int h, a, gmin;
        for (int i = 0; i < 15; i++) begin
            h    = $urandom_range(1, 12);
            a    = (h > HOLD) ? h : HOLD;
            gmin = SYNC + 2 + a - h;
            run_hs(h, gmin + $urandom_range(0, 5), -10);
        end
    endtask

    task automatic test_timeout();
        // clr_err lands on the very edge the timeout fires: the set wins
        run_hs(2000, 10, SYNC + TO);
        @(posedge clk); #1 clr_err = 1'b1;
        @(negedge clk);
        n_checks++;
        if (err_timeout !== 1'b1) $display("FAIL clr_before_edge got=%b exp=1", err_timeout);
        else n_pass++;
        @(posedge clk); #1 clr_err = 1'b0;
        err_m = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err_timeout !== 1'b0) $display("FAIL clr_after_edge got=%b exp=0", err_timeout);
        else n_pass++;
    endtask

    task automatic test_gated();
        int pulses;
        @(posedge clk); #1 en = 1'b0; chip_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if ({chip_ack, request_z} !== 2'b00)
                $display("FAIL gated_hold c=%0d got=%b exp=00", c, {chip_ack, request_z});
            else n_pass++;
        end
        @(posedge clk); #1 en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (chip_ack !== 1'b0) $display("FAIL gated_pre_en got=%b exp=0", chip_ack);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({chip_ack, request_z} !== 2'b11)
            $display("FAIL gated_accept got=%b exp=11", {chip_ack, request_z});
        else n_pass++;
        evt_exp++;
        @(posedge clk); #1 en = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({chip_ack, request_z} !== 2'b10)
            $display("FAIL gated_en_drop got=%b exp=10", {chip_ack, request_z});
        else n_pass++;
        @(posedge clk); #1 chip_req = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (request_z === 1'b1) pulses++;
        end
        n_checks++;
        if (chip_ack !== 1'b0) $display("FAIL gated_complete_ack got=%b exp=0", chip_ack);
        else n_pass++;
        n_checks++;
        if (pulses != 0) $display("FAIL gated_extra_pulse got=%0d exp=0", pulses);
        else n_pass++;
        n_checks++;
        if (evt_cnt !== 16'(evt_exp)) $display("FAIL gated_evt_cnt got=%0d exp=%0d", evt_cnt, evt_exp);
        else n_pass++;
        en = 1'b1;
    endtask

    task automatic test_saturation();
        int pulses, exp_cnt;
        for (int k = 1; k <= 5; k++) begin
            pulses = 0;
            @(posedge clk); #1 req2 = 1'b1;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                if (c == 4) req2 = 1'b0;
                @(negedge clk);
                if (pz2 === 1'b1) pulses++;
            end
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (pz2 === 1'b1) pulses++;
            end
            exp_cnt = (k > 3) ? 3 : k;
            n_checks++;
            if (cnt2 !== 2'(exp_cnt)) $display("FAIL sat_cnt k=%0d got=%0d exp=%0d", k, cnt2, exp_cnt);
            else n_pass++;
            n_checks++;
            if (pulses != 1) $display("FAIL sat_pulses k=%0d got=%0d exp=1", k, pulses);
            else n_pass++;
            n_checks++;
            if (ack2 !== 1'b0) $display("FAIL sat_ack_idle k=%0d got=%b exp=0", k, ack2);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int  waited;
        bit  seen;
        seen = 1'b0;
        @(posedge clk); #1 chip_req = 1'b1;
        for (waited = 0; waited < 10 && !seen; waited++) begin
            @(negedge clk);
            if (chip_ack === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL rstmid_wait_ack got=timeout exp=ack within 10 cycles");
        else n_pass++;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({chip_ack, request_z, err_timeout} !== 3'b000)
            $display("FAIL rstmid_async_flags got=%b exp=000", {chip_ack, request_z, err_timeout});
        else n_pass++;
        n_checks++;
        if (evt_cnt !== 16'd0) $display("FAIL rstmid_evt_cnt got=%0d exp=0", evt_cnt);
        else n_pass++;
        n_checks++;
        if (dbg_state !== ST_IDLE) $display("FAIL rstmid_state got=%0d exp=0", dbg_state);
        else n_pass++;
        evt_exp = 0;
        err_m   = 1'b0;
        chip_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({chip_ack, request_z} !== 2'b00)
                $display("FAIL rstmid_after c=%0d got=%b exp=00", c, {chip_ack, request_z});
            else n_pass++;
        end
        run_hs(6, 6, -10);
    endtask

    initial begin
        test_reset();
        test_single();
        test_short();
        test_random();
        test_timeout();
        test_gated();
        test_saturation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_aer_req_rx
